pipe_control: RTL and testbench

//  Pipelined successor to the single-cycle LEGv8 decoder. Decodes the opcode in ID (B, B.LT, ADDI, ADDS,
//  CBZ, LDUR, STUR, SUBS, LSL, LSR, MUL) and registers the control word into the ID/EX stage register.

---
 rtl/pipe_control.sv | 201 ++++++++++++++++++++
 tb/tb_pipe_control.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// ID-stage decoder and ID/EX control register for the pipelined LEGv8 core.
// Handles load-use stalls, multi-cycle MUL hold, EX-branch flush and illegal-opcode reporting.
module pipe_control #(
    parameter int OPW     = 11,
    parameter int REGW    = 5,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [31:0]     instr,
    input  logic            ex_flush,
    output logic            id_stall,
    output logic            ex_valid,
    output logic            ex_reg2loc,
    output logic            ex_alusrc,
    output logic            ex_memtoreg,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch,
    output logic            ex_uncond,
    output logic            ex_setflags,
    output logic [1:0]      ex_aluop,
    output logic            ex_mul,
    output logic [REGW-1:0] ex_rd,
    output logic [REGW-1:0] ex_rn,
    output logic [REGW-1:0] ex_rm,
    output logic            ex_illegal
);

    localparam int CW = $clog2(MUL_LAT) + 1;
    localparam logic [REGW-1:0] XZR       = '1;
    localparam logic [CW-1:0]   HOLD_INIT = CW'(MUL_LAT - 1);

    typedef struct packed {
        logic            valid;
        logic            reg2loc;
        logic            alusrc;
        logic            memtoreg;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            branch;
        logic            uncond;
        logic            setflags;
        logic [1:0]      aluop;
        logic            mul;
        logic            illegal;
        logic [REGW-1:0] rd;
        logic [REGW-1:0] rn;
        logic [REGW-1:0] rm;
    } ctrl_t;

    ctrl_t           word_reg, word_next, dec_word;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [OPW-1:0]  op;
    logic [REGW-1:0] f_rd, f_rn, f_rm;
    logic [REGW-1:0] src_idx [3];
    logic [2:0]      use_src;      // [0] rd as source, [1] rn, [2] rm
    logic [2:0]      src_hit;
    logic            legal;
    logic            load_use;
    logic            unused_instr_bits;

    assign op   = instr[31:32-OPW];
    assign f_rd = instr[REGW-1:0];
    assign f_rn = instr[5 +: REGW];
    assign f_rm = instr[16 +: REGW];
    assign unused_instr_bits = ^instr[15:10];

    assign src_idx[0] = f_rd;
    assign src_idx[1] = f_rn;
    assign src_idx[2] = f_rm;

    always_comb begin
        dec_word       = '0;
        dec_word.valid = 1'b1;
        dec_word.rd    = f_rd;
        dec_word.rn    = f_rn;
        dec_word.rm    = f_rm;
        use_src        = 3'b000;
        legal          = 1'b1;
        casez (op)
            11'b000101?????: begin
                dec_word.branch = 1'b1;
                dec_word.uncond = 1'b1;
                dec_word.aluop  = 2'b01;
            end
            11'b01010100???: begin
                dec_word.branch = 1'b1;
                dec_word.aluop  = 2'b01;
            end
            11'b10110100???: begin
                dec_word.reg2loc = 1'b1;
                dec_word.branch  = 1'b1;
                dec_word.aluop   = 2'b01;
                use_src          = 3'b011;
            end
            11'b1001000100?: begin
                dec_word.alusrc   = 1'b1;
                dec_word.regwrite = 1'b1;
                dec_word.aluop    = 2'b11;
                use_src           = 3'b010;
            end
            11'b10101011000, 11'b11101011000: begin
                dec_word.regwrite = 1'b1;
                dec_word.setflags = 1'b1;
                dec_word.aluop    = 2'b10;
                use_src           = 3'b110;
            end
            11'b10011011000: begin
                dec_word.regwrite = 1'b1;
                dec_word.mul      = 1'b1;
                dec_word.aluop    = 2'b10;
                use_src           = 3'b110;
            end
            // Shifts take the shamt from the immediate path, so rm is not read.
            11'b11010011011, 11'b11010011010: begin
                dec_word.alusrc   = 1'b1;
                dec_word.regwrite = 1'b1;
                dec_word.aluop    = 2'b10;
                use_src           = 3'b010;
            end
            11'b11111000010: begin
                dec_word.alusrc   = 1'b1;
                dec_word.memtoreg = 1'b1;
                dec_word.regwrite = 1'b1;
                dec_word.memread  = 1'b1;
                use_src           = 3'b010;
            end
            11'b11111000000: begin
                dec_word.reg2loc  = 1'b1;
                dec_word.alusrc   = 1'b1;
                dec_word.memwrite = 1'b1;
                use_src           = 3'b011;
            end
            default: legal = 1'b0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src_cmp
            assign src_hit[gi] = use_src[gi] & (src_idx[gi] == word_reg.rd);
        end
    endgenerate

    assign load_use = word_reg.valid & word_reg.memread & (word_reg.rd != XZR)
                    & id_valid & (|src_hit);

    assign id_stall = ~ex_flush & ((cnt_reg != '0) | load_use);

    always_comb begin
        word_next = word_reg;
        cnt_next  = cnt_reg;
        if (ex_flush) begin
            word_next = '0;
            cnt_next  = '0;
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CW'(1);
        end else if (load_use || !id_valid) begin
            word_next = '0;
        end else if (!legal) begin
            word_next         = '0;
            word_next.illegal = 1'b1;
        end else begin
            word_next = dec_word;
            if (dec_word.mul) begin
                cnt_next = HOLD_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            word_reg <= word_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign ex_valid    = word_reg.valid;
    assign ex_reg2loc  = word_reg.reg2loc;
    assign ex_alusrc   = word_reg.alusrc;
    assign ex_memtoreg = word_reg.memtoreg;
    assign ex_regwrite = word_reg.regwrite;
    assign ex_memread  = word_reg.memread;
    assign ex_memwrite = word_reg.memwrite;
    assign ex_branch   = word_reg.branch;
    assign ex_uncond   = word_reg.uncond;
    assign ex_setflags = word_reg.setflags;
    assign ex_aluop    = word_reg.aluop;
    assign ex_mul      = word_reg.mul;
    assign ex_illegal  = word_reg.illegal;
    assign ex_rd       = word_reg.rd;
    assign ex_rn       = word_reg.rn;
    assign ex_rm       = word_reg.rm;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: random and directed instruction streams checked
// against an instruction-level reference model.
module tb_pipe_control;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] instr;
    logic        ex_flush;
    logic        id_stall, ex_valid, ex_reg2loc, ex_alusrc, ex_memtoreg, ex_regwrite;
    logic        ex_memread, ex_memwrite, ex_branch, ex_uncond, ex_setflags, ex_mul, ex_illegal;
    logic [1:0]  ex_aluop;
    logic [4:0]  ex_rd, ex_rn, ex_rm;

    pipe_control #(.OPW(11), .REGW(5), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .instr(instr), .ex_flush(ex_flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_reg2loc(ex_reg2loc), .ex_alusrc(ex_alusrc),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_uncond(ex_uncond),
        .ex_setflags(ex_setflags), .ex_aluop(ex_aluop), .ex_mul(ex_mul),
        .ex_rd(ex_rd), .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid, reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch;
        logic       uncond, setflags;
        logic [1:0] aluop;
        logic       mul, illegal;
        logic [4:0] rd, rn, rm;
    } word_t;

    typedef enum int {K_B, K_BLT, K_CBZ, K_ADDI, K_ADDS, K_SUBS, K_LSL, K_LSR,
                      K_MUL, K_LDUR, K_STUR, K_ILL} kind_t;

    word_t dut_w;
    assign dut_w = {ex_valid, ex_reg2loc, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                    ex_memwrite, ex_branch, ex_uncond, ex_setflags, ex_aluop, ex_mul,
                    ex_illegal, ex_rd, ex_rn, ex_rm};

    int    n_checks = 0;
    int    n_pass   = 0;
    bit    stall_q[$];
    word_t ex_q[$];
    word_t m_ex;
    int    m_hold;

    function automatic kind_t kind_of(input logic [31:0] i);
        logic [10:0] op;
        op = i[31:21];
        if (op[10:5] == 6'b000101)        return K_B;
        if (op[10:3] == 8'b01010100)      return K_BLT;
        if (op[10:3] == 8'b10110100)      return K_CBZ;
        if (op[10:1] == 10'b1001000100)   return K_ADDI;
        if (op == 11'b10101011000)        return K_ADDS;
        if (op == 11'b11101011000)        return K_SUBS;
        if (op == 11'b11010011011)        return K_LSL;
        if (op == 11'b11010011010)        return K_LSR;
        if (op == 11'b10011011000)        return K_MUL;
        if (op == 11'b11111000010)        return K_LDUR;
        if (op == 11'b11111000000)        return K_STUR;
        return K_ILL;
    endfunction

    // Control table: reg2loc alusrc memtoreg regwrite memread memwrite branch | aluop
    function automatic word_t expect_word(input logic [31:0] i);
        word_t      w;
        logic [8:0] cw;
        kind_t      k;
        k = kind_of(i);
        case (k)
            K_ADDS, K_SUBS, K_MUL: cw = 9'b0001000_10;
            K_LSL, K_LSR:          cw = 9'b0101000_10;
            K_ADDI:                cw = 9'b0101000_11;
            K_LDUR:                cw = 9'b0111100_00;
            K_STUR:                cw = 9'b1100010_00;
            K_CBZ:                 cw = 9'b1000001_01;
            default:               cw = 9'b0000001_01;
        endcase
        w = '0;
        w.valid = 1'b1;
        {w.reg2loc, w.alusrc, w.memtoreg, w.regwrite, w.memread, w.memwrite, w.branch, w.aluop} = cw;
        w.uncond   = (k == K_B);
        w.setflags = (k == K_ADDS) || (k == K_SUBS);
        w.mul      = (k == K_MUL);
        w.rd = i[4:0];
        w.rn = i[9:5];
        w.rm = i[20:16];
        return w;
    endfunction

    function automatic bit reads_reg(input logic [31:0] i, input logic [4:0] r);
        case (kind_of(i))
            K_ADDS, K_SUBS, K_MUL:          return (i[9:5] == r) || (i[20:16] == r);
            K_LSL, K_LSR, K_ADDI, K_LDUR:   return (i[9:5] == r);
            K_STUR, K_CBZ:                  return (i[9:5] == r) || (i[4:0] == r);
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input kind_t k, input logic [4:0] rd,
                                       input logic [4:0] rn, input logic [4:0] rm);
        logic [31:0] i;
        i = $urandom;
        i[4:0]   = rd;
        i[9:5]   = rn;
        i[20:16] = rm;
        case (k)
            K_B:    i[31:26] = 6'b000101;
            K_BLT:  i[31:24] = 8'b01010100;
            K_CBZ:  i[31:24] = 8'b10110100;
            K_ADDI: i[31:22] = 10'b1001000100;
            K_ADDS: i[31:21] = 11'b10101011000;
            K_SUBS: i[31:21] = 11'b11101011000;
            K_LSL:  i[31:21] = 11'b11010011011;
            K_LSR:  i[31:21] = 11'b11010011010;
            K_MUL:  i[31:21] = 11'b10011011000;
            K_LDUR: i[31:21] = 11'b11111000010;
            K_STUR: i[31:21] = 11'b11111000000;
            default: begin
                do i[31:21] = 11'($urandom); while (kind_of(i) != K_ILL);
            end
        endcase
        return i;
    endfunction

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(0, 3));
    endfunction

    task automatic model_step(input bit v, input logic [31:0] i, input bit fl, output bit stall);
        bit lu;
        lu = m_ex.valid && m_ex.memread && (m_ex.rd != 5'd31) && v && reads_reg(i, m_ex.rd);
        stall = !fl && (m_hold > 0 || lu);
        if (fl) begin
            m_ex   = '0;
            m_hold = 0;
        end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
        end else if (lu || !v) begin
            m_ex = '0;
        end else if (kind_of(i) == K_ILL) begin
            m_ex = '0;
            m_ex.illegal = 1'b1;
        end else begin
            m_ex = expect_word(i);
            if (m_ex.mul) m_hold = MUL_LAT - 1;
        end
    endtask

    task automatic check_word(input string name, input word_t got, input word_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
    endtask

    task automatic drive(input bit v, input logic [31:0] i, input bit fl);
        bit s;
        @(negedge clk);
        reset    = 1'b1;
        id_valid = v;
        instr    = i;
        ex_flush = fl;
        model_step(v, i, fl, s);
        stall_q.push_back(s);
        ex_q.push_back(m_ex);
        $display("txn t=%0t v=%0b instr=%h flush=%0b -> stall=%0b next=%h", $time, v, i, fl, s, m_ex);
    endtask

    // Asserts reset mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic reset_pulse();
        @(negedge clk);
        reset    = 1'b0;
        id_valid = 1'b1;
        instr    = mk(K_ADDI, 5'd1, 5'd2, 5'd0);
        ex_flush = 1'b0;
        #1;
        check_word("reset_async_ex", dut_w, '0);
        check_bit("reset_async_stall", id_stall, 1'b0);
        m_ex   = '0;
        m_hold = 0;
        @(posedge clk);
        #1;
        check_word("reset_held_ex", dut_w, '0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                #2;
                if (stall_q.size() > 0) check_bit("id_stall", id_stall, stall_q.pop_front());
            end
            forever begin
                @(posedge clk);
                #1;
                if (ex_q.size() > 0) check_word("ex_word", dut_w, ex_q.pop_front());
            end
        join_none
    end

    initial begin
        logic [31:0] addi, ld, adds;
        m_ex     = '0;
        m_hold   = 0;
        reset    = 1'b1;
        id_valid = 1'b1;
        ex_flush = 1'b0;
        addi     = mk(K_ADDI, 5'd1, 5'd2, 5'd0);
        instr    = addi;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_word("reset_ex", dut_w, '0);
        check_bit("reset_stall", id_stall, 1'b0);
        drive(1, addi, 0);

        // load-use on rn, then the held ADDS reissues
        ld   = mk(K_LDUR, 5'd2, 5'd0, 5'd0);
        adds = mk(K_ADDS, 5'd3, 5'd2, 5'd4);
        drive(1, ld, 0);
        drive(1, adds, 0);
        drive(1, adds, 0);
        // XZR destination never creates a hazard
        drive(1, mk(K_LDUR, 5'd31, 5'd0, 5'd0), 0);
        drive(1, mk(K_ADDS, 5'd3, 5'd31, 5'd4), 0);
        drive(0, 32'd0, 0);
        // MUL hold, then the waiting ADDI issues
        drive(1, mk(K_MUL, 5'd5, 5'd1, 5'd2), 0);
        repeat (3) drive(1, addi, 0);
        // flush during MUL hold and during a load-use stall
        drive(1, mk(K_MUL, 5'd5, 5'd1, 5'd2), 0);
        drive(1, addi, 1);
        drive(1, addi, 0);
        drive(1, ld, 0);
        drive(1, adds, 1);
        drive(1, adds, 0);
        // illegal opcode pulse
        drive(1, 32'h0000_0000, 0);
        drive(1, addi, 0);
        // reset in the middle of a MUL hold
        drive(1, mk(K_MUL, 5'd6, 5'd1, 5'd2), 0);
        reset_pulse();
        drive(1, addi, 0);

        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) reset_pulse();
            drive($urandom_range(0, 9) != 0,
                  mk(kind_t'($urandom_range(0, 11)), rand_reg(), rand_reg(), rand_reg()),
                  $urandom_range(0, 11) == 0);
        end
        drive(0, 32'd0, 0);
        drive(0, 32'd0, 0);
        @(posedge clk);
        #3;
        n_checks++;
        if (stall_q.size() == 0 && ex_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d/%0d pending entries, required 0/0", stall_q.size(), ex_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
